// File: rtl/echo_player.sv
// Echo playback engine: per audio tick, reads the dry sample plus two delayed
// taps from the sample buffer, mixes them with 1/2 and 1/4 gains, and saturates.
module echo_player #(
   parameter int ADDR_W = 16,
   parameter int TAP1   = 1500,
   parameter int TAP2   = 3000,
   parameter int RD_LAT = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     play_in,
   input  logic                     loop_in,
   input  logic [ADDR_W-1:0]        length_in,
   input  logic                     audio_valid_in,
   output logic [ADDR_W-1:0]        rd_addr_out,
   input  logic signed [7:0]        rd_data_in,
   output logic signed [7:0]        sample_out,
   output logic                     sample_valid_out,
   output logic                     busy_out,
   output logic                     done_out
);
   localparam int CNT_W = $clog2(RD_LAT + 4);
   localparam logic [CNT_W-1:0] CAP_DRY = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] CAP_T1  = CNT_W'(RD_LAT + 1);
   localparam logic [CNT_W-1:0] CAP_T2  = CNT_W'(RD_LAT + 2);
   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(2);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_OUT} state_t;

   state_t              state, state_nx;
   logic                play_q;
   logic [ADDR_W-1:0]   len, p;
   logic [CNT_W-1:0]    cnt;
   logic signed [7:0]   dry_q, tap1_q, tap2_d, half1, quart2, sat;
   logic signed [9:0]   mix;
   logic                start, last, tap1_ok, tap2_ok;

   assign start   = play_in && !play_q;
   assign last    = (p == len - 1'b1);
   assign tap1_ok = (p >= ADDR_W'(TAP1));
   assign tap2_ok = (p >= ADDR_W'(TAP2));

   // Taps that would reach before address 0 contribute silence, including after a loop wrap.
   assign tap2_d = tap2_ok ? rd_data_in : 8'sd0;
   assign half1  = tap1_q >>> 1;
   assign quart2 = tap2_d >>> 2;
   assign mix    = {{2{dry_q[7]}}, dry_q} + {{2{half1[7]}}, half1} + {{2{quart2[7]}}, quart2};

   always_comb begin
      if (mix > 10'sd127)
         sat = 8'sd127;
      else if (mix < -10'sd128)
         sat = -8'sd128;
      else
         sat = mix[7:0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy_out = (state != S_IDLE);
      case (state)
         S_IDLE:  if (start && length_in != '0) state_nx = S_WAIT;
         S_WAIT:  if (audio_valid_in) state_nx = S_ISSUE;
         S_ISSUE: begin
            if (cnt == CAP_T2)
               state_nx = S_OUT;
            else if (cnt == LAST_RD)
               state_nx = S_DRAIN;
         end
         S_DRAIN: if (cnt == CAP_T2) state_nx = S_OUT;
         S_OUT:   state_nx = done_out ? S_IDLE : S_WAIT;
         default: state_nx = S_IDLE;
      endcase
      // Dropping play aborts from anywhere; the in-flight sample never reaches OUT.
      if (state != S_IDLE && !play_in)
         state_nx = S_IDLE;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         play_q           <= 1'b0;
         len              <= '0;
         p                <= '0;
         cnt              <= '0;
         rd_addr_out      <= '0;
         dry_q            <= '0;
         tap1_q           <= '0;
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
         done_out         <= 1'b0;
      end else begin
         play_q           <= play_in;
         sample_valid_out <= 1'b0;
         done_out         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (state_nx == S_WAIT) begin
                  len <= length_in;
                  p   <= '0;
               end
            end
            S_WAIT: begin
               if (state_nx == S_ISSUE) begin
                  rd_addr_out <= p;
                  cnt         <= '0;
               end
            end
            S_ISSUE, S_DRAIN: begin
               cnt <= cnt + 1'b1;
               if (state == S_ISSUE && cnt == '0)
                  rd_addr_out <= p - ADDR_W'(TAP1);
               if (state == S_ISSUE && cnt == CNT_W'(1))
                  rd_addr_out <= p - ADDR_W'(TAP2);
               if (cnt == CAP_DRY)
                  dry_q <= rd_data_in;
               if (cnt == CAP_T1)
                  tap1_q <= tap1_ok ? rd_data_in : 8'sd0;
               if (state_nx == S_OUT) begin
                  sample_out       <= sat;
                  sample_valid_out <= 1'b1;
                  done_out         <= last && !loop_in;
               end
            end
            S_OUT: begin
               if (state_nx == S_WAIT)
                  p <= last ? '0 : p + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_echo_player.sv
// Scoreboard bench for echo_player: expected mixes are queued per tick from a
// reference model over the bench's buffer image and popped on each valid pulse.
module tb_echo_player;
   localparam int AW  = 16;
   localparam int T1  = 2;
   localparam int T2  = 4;
   localparam int LAT = 2;

   logic clk = 1'b0, rst_n = 1'b0, play = 1'b0, loop = 1'b0, tick = 1'b0;
   logic [AW-1:0] len = '0, rd_addr, a1, a2;
   logic signed [7:0] rd_data, sample;
   logic valid, busy, done;
   logic signed [7:0] mem [0:15];

   typedef struct {
      logic signed [7:0] s;
      logic              d;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   echo_player #(.ADDR_W(AW), .TAP1(T1), .TAP2(T2), .RD_LAT(LAT)) dut (
      .clk_in(clk), .rst_in(rst_n), .play_in(play), .loop_in(loop),
      .length_in(len), .audio_valid_in(tick), .rd_addr_out(rd_addr),
      .rd_data_in(rd_data), .sample_out(sample), .sample_valid_out(valid),
      .busy_out(busy), .done_out(done)
   );

   // Two-cycle read latency buffer; out-of-range addresses return junk so unmasked taps show up.
   always @(posedge clk) begin
      a1 <= rd_addr;
      a2 <= a1;
   end
   assign rd_data = (a2 < AW'(16)) ? mem[a2[3:0]] : 8'sh9d;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid sample=%0d done=%0d", sample, done);
            end else begin
               mon_e = sb.pop_front();
               if (sample !== mon_e.s || done !== mon_e.d) begin
                  errors++;
                  $display("FAIL sample got=%0d done=%0d exp=%0d done=%0d", sample, done, mon_e.s, mon_e.d);
               end
            end
         end else if (done) begin
            checks++;
            errors++;
            $display("FAIL stray_done without valid");
         end
      end
   end

   function automatic logic signed [7:0] model(input int p);
      int acc, t;
      acc = mem[p];
      if (p >= T1) begin
         t = mem[p-T1];
         acc += t >>> 1;
      end
      if (p >= T2) begin
         t = mem[p-T2];
         acc += t >>> 2;
      end
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      return 8'(acc);
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int n, input int v0, input int v1, input int v2,
                       input int v3, input int v4, input int v5);
      int v[6];
      v = '{v0, v1, v2, v3, v4, v5};
      for (int i = 0; i < 16; i++) mem[i] = (i < n) ? 8'(v[i]) : 8'sd0;
   endtask

   task automatic start(input int n, input logic lp);
      @(negedge clk);
      len  = AW'(n);
      loop = lp;
      play = 1'b1;
   endtask

   task automatic stop();
      @(negedge clk);
      play = 1'b0;
      cyc(2);
   endtask

   task automatic do_tick(input int p, input logic d);
      exp_t e;
      e.s = model(p);
      e.d = d;
      sb.push_back(e);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      cyc(12);
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s pending=%0d exp=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(3);
      checks += 5;
      if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rd_addr); end
      if (sample !== 8'sd0) begin errors++; $display("FAIL reset_sample got=%0d exp=0", sample); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_zero_len();
      start(0, 1'b0);
      cyc(3);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got=%0b exp=0", busy); end
      stop();
   endtask

   task automatic test_dry();
      exp_t e;
      load(3, 10, 20, 30, 0, 0, 0);
      start(3, 1'b0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%0b exp=1", busy); end
      do_tick(0, 1'b0);
      do_tick(1, 1'b0);
      e.s = model(2);
      e.d = 1'b1;
      sb.push_back(e);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      checks++;
      if (rd_addr !== AW'(2)) begin errors++; $display("FAIL addr_dry got=%0d exp=2", rd_addr); end
      @(negedge clk);
      checks++;
      if (rd_addr !== AW'(0)) begin errors++; $display("FAIL addr_tap1 got=%0d exp=0", rd_addr); end
      @(negedge clk);
      checks++;
      if (rd_addr !== 16'hfffe) begin errors++; $display("FAIL addr_tap2 got=%0d exp=65534", rd_addr); end
      cyc(2);
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%0b exp=0", valid); end
      @(negedge clk);
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%0b exp=1", valid); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL done_idle_busy got=%0b exp=0", busy); end
      wait_empty("dry_queue");
      stop();
   endtask

   task automatic test_full_mix();
      load(6, 8, 0, 0, 0, 0, 4);
      start(6, 1'b0);
      for (int p = 0; p < 6; p++) do_tick(p, p == 5);
      wait_empty("mix_queue");
      stop();
   endtask

   task automatic test_saturation();
      load(5, 100, 0, 120, 0, 100, 0);
      start(5, 1'b0);
      for (int p = 0; p < 5; p++) do_tick(p, p == 4);
      wait_empty("sat_pos_queue");
      stop();
      load(5, -128, 0, -128, 0, -128, 0);
      start(5, 1'b0);
      for (int p = 0; p < 5; p++) do_tick(p, p == 4);
      wait_empty("sat_neg_queue");
      stop();
   endtask

   task automatic test_loop();
      load(2, 5, 7, 0, 0, 0, 0);
      start(2, 1'b1);
      for (int k = 0; k < 5; k++) do_tick(k % 2, 1'b0);
      loop = 1'b0;
      do_tick(1, 1'b1);
      wait_empty("loop_queue");
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL loop_end_busy got=%0b exp=0", busy); end
      stop();
   endtask

   task automatic test_abort();
      exp_t e;
      load(3, 10, 20, 30, 0, 0, 0);
      start(3, 1'b0);
      do_tick(0, 1'b0);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      play = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", busy); end
      cyc(10);
      checks++;
      if (sample !== 8'sd10) begin errors++; $display("FAIL abort_hold got=%0d exp=10", sample); end
      start(3, 1'b0);
      e.s = model(0);
      e.d = 1'b0;
      sb.push_back(e);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      checks++;
      if (rd_addr !== AW'(0)) begin errors++; $display("FAIL restart_addr got=%0d exp=0", rd_addr); end
      cyc(12);
      wait_empty("abort_queue");
      stop();
   endtask

   task automatic test_reset_mid_drain();
      load(3, 10, 20, 30, 0, 0, 0);
      start(3, 1'b0);
      do_tick(0, 1'b0);
      do_tick(1, 1'b0);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      cyc(3);
      #2 rst_n = 1'b0;
      #1;
      checks += 5;
      if (rd_addr !== '0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", rd_addr); end
      if (sample !== 8'sd0) begin errors++; $display("FAIL mid_rst_sample got=%0d exp=0", sample); end
      if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b exp=0", valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%0b exp=0", done); end
      play = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(12);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%0b exp=0", busy); end
      wait_empty("reset_queue");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'sd0;
      test_reset();
      test_zero_len();
      test_dry();
      test_full_mix();
      test_saturation();
      test_loop();
      test_abort();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/echo_player.md
# echo_player

Playback engine that reads 8-bit signed audio samples back out of the shared sample BRAM written by the recording path. The block steps through addresses 0..length-1 at the audio sample rate. For each output sample it mixes the current sample with two delayed copies from the same buffer to produce an echo, and it can loop continuously. It sits between the buffer's read port and the audio output stage (PWM/DAC feed).

## Interface
- ADDR_W, 16, width of the buffer address and length
- TAP1, 1500, first echo delay in samples, mixed at 1/2 gain
- TAP2, 3000, second echo delay in samples, mixed at 1/4 gain
- RD_LAT, 2, read latency of the buffer: cycles from address to data
- clk_in  input  1  system clock; the only clock
- rst_in  input  1  asynchronous, active-low reset
- play_in  input  1  rising edge starts playback; low aborts it
- loop_in  input  1  sampled at end of buffer; 1 = wrap to address 0
- length_in  input  ADDR_W  number of valid samples; latched at start
- audio_valid_in  input  1  one-cycle sample-rate tick
- rd_addr_out  output  ADDR_W  buffer read address, registered
- rd_data_in  input  8  signed buffer data, valid RD_LAT cycles after the address
- sample_out  output  8  signed mixed sample, held between updates
- sample_valid_out  output  1  one-cycle pulse when sample_out updates
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  one-cycle pulse after the last sample of a non-looping pass

## Operation
- States:
  - IDLE
  - WAIT: playing, waiting for a tick
  - ISSUE: 3 cycles, one per read
  - DRAIN: waiting for read data
  - OUT
- IDLE -> WAIT: on a play_in rising edge with length_in != 0.
  - Latch length_in into len.
  - Set position p = 0.
  - A rising edge with length_in == 0 is ignored and produces no done pulse.
- WAIT -> ISSUE: on audio_valid_in.
- ISSUE: issue three reads, one per cycle, in order: p, p-TAP1, p-TAP2.
  - A tap with p < TAP still issues its read, but its data is forced to 0 in the mix.
- DRAIN: lasts until the third read's data has been captured (RD_LAT cycles).
- OUT: compute the mix and assert sample_valid_out for one cycle.
  - mix = dry + (tap1 >>> 1) + (tap2 >>> 2), computed in 10-bit signed arithmetic.
  - Shifts are arithmetic.
  - The result saturates to [-128, 127].
- After OUT:
  - If p != len-1: p increments and the FSM returns to WAIT.
  - If p == len-1 and loop_in = 1: p = 0, return to WAIT, no done pulse.
  - If p == len-1 and loop_in = 0: done_out pulses for one cycle with the final sample_valid_out, then IDLE.
- Echo taps do not wrap across the loop boundary. After a wrap, p < TAP again forces zeros.
- audio_valid_in outside WAIT is ignored and the tick is dropped. The sample period of 2000+ cycles far exceeds the per-sample cost of 3+RD_LAT+1 cycles.
- play_in low in any non-IDLE state:
  - Next state is IDLE.
  - The in-flight sample is discarded: no sample_valid_out, no done_out.
  - sample_out keeps its last value.
- play_in edge detection uses a registered copy of play_in. Holding play_in high after done does not restart playback.

## Timing
- Reset values (asynchronous, rst_in = 0): state IDLE; rd_addr_out, sample_out and p all 0; sample_valid_out, busy_out and done_out all 0.
- With a tick at cycle T in WAIT:
  - rd_addr_out = p at T+1, p-TAP1 at T+2, p-TAP2 at T+3.
  - The data for these reads is captured at T+1+RD_LAT, T+2+RD_LAT and T+3+RD_LAT.
  - sample_valid_out is high at T+4+RD_LAT (T+6 at the default).
- Address arithmetic for p-TAP is computed modulo 2^ADDR_W. Its value is don't-care when p < TAP because the data is masked.
- busy_out rises the cycle after the start edge and falls in the cycle IDLE is entered.
- A tick arriving in the same cycle as the start edge is ignored; playback waits for the next tick.

## Test plan
- Dry only. Parameters TAP1=2, TAP2=4; memory [10, 20, 30]; length 3; loop off; ticks every 50 cycles.
  - Required: sample_out = 10, 20, 15+... Exact expected sequence: 10, 20, 35 (30 + 10>>>1).
  - done_out is coincident with the third valid pulse, followed by IDLE.
- Full mix. TAP1=2, TAP2=4; memory 0..5 = [8, 0, 0, 0, 0, 4]; length 6.
  - Required sixth output: 4 + (0>>>1) + (0>>>2) = 4.
  - Required fifth output: 0 + (0>>>1) + (8>>>2) = 2.
- Saturation.
  - dry 100, tap1 120, tap2 100 -> 185 -> required output 127.
  - dry -128, tap1 -128, tap2 -128 -> -224 -> required output -128.
- Loop. length 2, loop_in = 1, memory [5, 7], TAP1=2.
  - Required outputs: 5, 7, 5, 7, ... (tap masked after each wrap).
  - No done_out pulse.
  - Dropping loop_in before the next end yields one done_out pulse.
- Abort. Drop play_in one cycle after a tick, during ISSUE.
  - Required: no sample_valid_out, no done_out, busy_out = 0 within 1 cycle, sample_out unchanged.
  - A new rising edge restarts from address 0.
- Reset mid-DRAIN. Assert rst_in low asynchronously.
  - Required: all outputs read 0 in the same cycle, FSM in IDLE.
  - No spurious valid pulse after release.
